// File: rtl/wbmem_responder.sv
// Pipelined Wishbone slave memory: on-chip RAM behind a fixed-latency response
// pipeline, with bus errors outside its address window and an optional
// periodic stall pattern for exercising master stall handling.
module wbmem_responder #(
    parameter int              AW          = 24,
    parameter int              LGMEMSZ     = 10,
    parameter logic [AW-1:0]   BASE        = '0,
    parameter int              LATENCY     = 2,
    parameter int              STALLPERIOD = 0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wb_cyc,
    input  logic          i_wb_stb,
    input  logic          i_wb_we,
    input  logic [AW-1:0] i_wb_addr,
    input  logic [31:0]   i_wb_data,
    output logic          o_wb_ack,
    output logic          o_wb_stall,
    output logic          o_wb_err,
    output logic [31:0]   o_wb_data
);

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("wbmem_responder: LATENCY must lie in 1..4");
    end

    localparam int          MEMDEPTH  = 1 << LGMEMSZ;
    localparam int          CW        = (STALLPERIOD > 1) ? $clog2(STALLPERIOD) : 1;
    localparam int unsigned LASTCOUNT = (STALLPERIOD > 0) ? STALLPERIOD - 1 : 0;
    localparam logic [CW-1:0] LAST_CNT = CW'(LASTCOUNT);

    logic [31:0]         mem [MEMDEPTH];

    logic                accept;
    logic                hit;
    logic [LGMEMSZ-1:0]  index;
    logic [31:0]         rdData;

    logic [LATENCY-1:0]  valid_q, valid_d;
    logic [LATENCY-1:0]  err_q, err_d;
    logic [31:0]         data_q [LATENCY];
    logic [31:0]         data_d [LATENCY];

    logic                stall_q, stall_d;
    logic [CW-1:0]       stallCnt_q, stallCnt_d;

    // Decode the request: an accept needs cyc, stb and no stall this cycle.
    always_comb begin
        accept = i_wb_cyc & i_wb_stb & ~stall_q;
        hit    = (i_wb_addr[AW-1:LGMEMSZ] == BASE[AW-1:LGMEMSZ]);
        index  = i_wb_addr[LGMEMSZ-1:0];
        rdData = (accept && !i_wb_we && hit) ? mem[index] : 32'h0;
    end

    // Memory array is deliberately left out of reset so contents survive it.
    always_ff @(posedge i_clk) begin
        if (accept && i_wb_we && hit) begin
            mem[index] <= i_wb_data;
        end
    end

    // Response pipeline shifts every clock; dropping cyc kills all in-flight beats.
    always_comb begin
        valid_d = '0;
        err_d   = '0;
        for (int i = 0; i < LATENCY; i++) begin
            data_d[i] = 32'h0;
        end
        data_d[0] = rdData;
        for (int i = 1; i < LATENCY; i++) begin
            data_d[i] = data_q[i-1];
        end
        if (i_wb_cyc) begin
            valid_d[0] = accept;
            err_d[0]   = accept & ~hit;
            for (int i = 1; i < LATENCY; i++) begin
                valid_d[i] = valid_q[i-1];
                err_d[i]   = err_q[i-1];
            end
        end
    end

    // Stall generator: one forced stall cycle after every STALLPERIOD accepts.
    always_comb begin
        stallCnt_d = stallCnt_q;
        stall_d    = 1'b0;
        if (!i_wb_cyc) begin
            stallCnt_d = '0;
        end else if (accept && (STALLPERIOD != 0)) begin
            if (stallCnt_q == LAST_CNT) begin
                stallCnt_d = '0;
                stall_d    = 1'b1;
            end else begin
                stallCnt_d = stallCnt_q + CW'(1);
            end
        end
    end

    // State registers for the response pipeline and the stall generator.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q    <= '0;
            err_q      <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= 32'h0;
            end
            stall_q    <= 1'b0;
            stallCnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            err_q      <= err_d;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= data_d[i];
            end
            stall_q    <= stall_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    // Bus outputs come straight from the final pipeline stage.
    always_comb begin
        o_wb_ack   = valid_q[LATENCY-1] & ~err_q[LATENCY-1];
        o_wb_err   = valid_q[LATENCY-1] & err_q[LATENCY-1];
        o_wb_data  = data_q[LATENCY-1];
        o_wb_stall = stall_q;
    end

endmodule

// File: tb/tb_wbmem_responder.sv
// Bench for wbmem_responder: two instances share one bus (A: latency 2, no
// stalls; B: latency 3, stall every 3 beats), each tracked by its own
// transaction-level model of memory contents and due-cycle responses.
module tb_wbmem_responder;

    logic        clk;
    logic        rstN;
    logic        cyc, stb, we;
    logic [23:0] addr;
    logic [31:0] wdat;

    logic        ack0, err0, stall0;
    logic [31:0] rdat0;
    logic        ack1, err1, stall1;
    logic [31:0] rdat1;

    int          total;
    int          bad;
    int          edgeNo;
    int          stbCycles;

    logic [31:0] mm    [2][1024];
    bit          slotV [2][16];
    bit          slotE [2][16];
    logic [31:0] slotD [2][16];
    int          mCnt  [2];
    bit          mStall[2];

    wbmem_responder #(.AW(24), .LGMEMSZ(10), .BASE(24'h000000), .LATENCY(2), .STALLPERIOD(0)) dutA (
        .i_clk(clk), .i_rst_n(rstN), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdat), .o_wb_ack(ack0), .o_wb_stall(stall0),
        .o_wb_err(err0), .o_wb_data(rdat0)
    );

    wbmem_responder #(.AW(24), .LGMEMSZ(10), .BASE(24'h000000), .LATENCY(3), .STALLPERIOD(3)) dutB (
        .i_clk(clk), .i_rst_n(rstN), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdat), .o_wb_ack(ack1), .o_wb_stall(stall1),
        .o_wb_err(err1), .o_wb_data(rdat1)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int latOf(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic int periodOf(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clearModel();
        for (int d = 0; d < 2; d++) begin
            for (int s = 0; s < 16; s++) slotV[d][s] = 1'b0;
            mCnt[d]   = 0;
            mStall[d] = 1'b0;
        end
    endtask

    task automatic applyStimulus(input bit c, input bit s, input bit w,
                                 input logic [23:0] a, input logic [31:0] dt);
        cyc  = c;
        stb  = s;
        we   = w;
        addr = a;
        wdat = dt;
    endtask

    // Compare both instances against the responses due at the current edge.
    task automatic checkOutput();
        int s;
        logic a, e, st;
        logic [31:0] dt;
        s = edgeNo % 16;
        for (int d = 0; d < 2; d++) begin
            a  = (d == 0) ? ack0   : ack1;
            e  = (d == 0) ? err0   : err1;
            st = (d == 0) ? stall0 : stall1;
            dt = (d == 0) ? rdat0  : rdat1;
            chk($sformatf("ack[%0d] edge %0d", d, edgeNo), 32'(a), 32'(slotV[d][s] && !slotE[d][s]));
            chk($sformatf("err[%0d] edge %0d", d, edgeNo), 32'(e), 32'(slotV[d][s] && slotE[d][s]));
            chk($sformatf("stall[%0d] edge %0d", d, edgeNo), 32'(st), 32'(mStall[d]));
            if (slotV[d][s]) begin
                chk($sformatf("data[%0d] edge %0d", d, edgeNo), dt, slotD[d][s]);
            end
            slotV[d][s] = 1'b0;
        end
    endtask

    // One clock: decide accepts from the model, take the edge, update, check.
    task automatic tick();
        bit acc [2];
        bit hit;
        int idx;
        int s;
        logic [31:0] rd;
        for (int d = 0; d < 2; d++) acc[d] = cyc && stb && !mStall[d];
        @(posedge clk);
        edgeNo++;
        hit = (addr[23:10] == 14'd0);
        idx = int'(addr[9:0]);
        for (int d = 0; d < 2; d++) begin
            if (!cyc) begin
                for (int k = 0; k < 16; k++) slotV[d][k] = 1'b0;
                mCnt[d]   = 0;
                mStall[d] = 1'b0;
            end else begin
                mStall[d] = 1'b0;
                if (acc[d]) begin
                    rd = (!we && hit) ? mm[d][idx] : 32'h0;
                    if (we && hit) mm[d][idx] = wdat;
                    s = (edgeNo + latOf(d) - 1) % 16;
                    slotV[d][s] = 1'b1;
                    slotE[d][s] = !hit;
                    slotD[d][s] = rd;
                    if (periodOf(d) != 0) begin
                        mCnt[d]++;
                        if (mCnt[d] == periodOf(d)) begin
                            mCnt[d]   = 0;
                            mStall[d] = 1'b1;
                        end
                    end
                end
            end
        end
        #1;
        checkOutput();
    endtask

    // Issue one beat, holding it while instance B reports stall.
    task automatic holdBeat(input bit w, input logic [23:0] a, input logic [31:0] dt);
        bit wasStalled;
        int tries;
        tries = 0;
        applyStimulus(1'b1, 1'b1, w, a, dt);
        do begin
            wasStalled = stall1;
            tick();
            tries++;
            stbCycles++;
        end while (wasStalled && tries < 8);
        chk("holdBound", 32'(wasStalled), 32'h0);
    endtask

    // Let in-flight responses complete, then end the bus cycle.
    task automatic drain();
        applyStimulus(1'b1, 1'b0, 1'b0, 24'h0, 32'h0);
        repeat (4) tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 24'h0, 32'h0);
        tick();
    endtask

    initial begin
        int idx;
        bit c, s, w, miss;
        logic [23:0] a;
        total  = 0;
        bad    = 0;
        edgeNo = 0;
        clearModel();
        rstN = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 24'h0, 32'h0);

        // Reset state of both instances.
        #2;
        chk("rstAck0", 32'(ack0), 32'h0);
        chk("rstErr0", 32'(err0), 32'h0);
        chk("rstStall1", 32'(stall1), 32'h0);
        chk("rstData1", rdat1, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;

        // Preload the working set.
        stbCycles = 0;
        for (int i = 0; i < 32; i++) holdBeat(1'b1, 24'(i), 32'h5000_0000 + 32'(i) * 32'h111);
        for (int i = 0; i < 8; i++) holdBeat(1'b1, 24'h100 + 24'(i), 32'hA0 + 32'(i));
        drain();

        // Back-to-back 8-beat read burst, no holding.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 24'h100 + 24'(i), 32'h0);
            tick();
        end
        drain();

        // Same burst honouring stalls from instance B.
        stbCycles = 0;
        for (int i = 0; i < 8; i++) holdBeat(1'b0, 24'h100 + 24'(i), 32'h0);
        chk("burstStbCycles", 32'(stbCycles), 32'd10);
        drain();

        // Out-of-window read followed by an in-window read.
        applyStimulus(1'b1, 1'b1, 1'b0, 24'h000400, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 24'h000005, 32'h0);
        tick();
        drain();

        // Write then immediate read of the same word.
        applyStimulus(1'b1, 1'b1, 1'b1, 24'h000010, 32'h12345678);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 24'h000010, 32'h0);
        tick();
        drain();

        // Abort with two reads in flight, stb without cyc, then a fresh read.
        applyStimulus(1'b1, 1'b1, 1'b0, 24'h000000, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 24'h000001, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 24'h000002, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 24'h000003, 32'h0);
        tick();
        drain();

        // Asynchronous reset mid-burst, then re-read a stored word.
        for (int i = 0; i < 3; i++) holdBeat(1'b0, 24'h100 + 24'(i), 32'h0);
        #2;
        rstN = 1'b0;
        clearModel();
        #1;
        chk("asyncAck0", 32'(ack0), 32'h0);
        chk("asyncErr0", 32'(err0), 32'h0);
        chk("asyncData0", rdat0, 32'h0);
        chk("asyncAck1", 32'(ack1), 32'h0);
        chk("asyncStall1", 32'(stall1), 32'h0);
        chk("asyncData1", rdat1, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 24'h0, 32'h0);
        tick();
        tick();
        #1;
        rstN = 1'b1;
        tick();
        holdBeat(1'b0, 24'h000010, 32'h0);
        drain();

        // Randomised traffic over the preloaded set plus out-of-window hits.
        for (int n = 0; n < 400; n++) begin
            c    = ($urandom_range(0, 15) != 0);
            s    = ($urandom_range(0, 3) != 0);
            w    = ($urandom_range(0, 2) == 0);
            miss = ($urandom_range(0, 7) == 0);
            idx  = $urandom_range(0, 39);
            if (idx >= 32) idx = 32'h100 + (idx - 32);
            a = {miss ? 14'($urandom_range(1, 16383)) : 14'd0, 10'(idx)};
            applyStimulus(c, s, w, a, $urandom);
            tick();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
